// File: rtl/sync_fifo.sv
// sync_fifo: parametrised single-clock FIFO with show-ahead output,
// occupancy count, full/empty/almost-full flags and sticky error flags.
module sync_fifo #(
  parameter int WIDTH    = 8,
  parameter int DEPTH    = 16,
  parameter int AF_LEVEL = DEPTH - 2,
  parameter int CW       = $clog2(DEPTH + 1)
) (
  input  logic             clock,
  input  logic             reset_l,
  input  logic             clear,
  input  logic             we,
  input  logic [WIDTH-1:0] D,
  input  logic             re,
  output logic [WIDTH-1:0] Q,
  output logic             empty,
  output logic             full,
  output logic             almost_full,
  output logic [CW-1:0]    count,
  output logic             overflow,
  output logic             underflow
);

  localparam int PW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]    rp_q, rp_d;
  logic [PW-1:0]    wp_q, wp_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             ovf_q, ovf_d;
  logic             unf_q, unf_d;
  logic             rd_ok, wr_ok;

  // Wrapping pointer increment; DEPTH need not be a power of two.
  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  // Status is derived from the registered count only, so no input reaches an output.
  always_comb begin
    empty       = (cnt_q == '0);
    full        = (cnt_q == CW'(DEPTH));
    almost_full = (cnt_q >= CW'(AF_LEVEL));
    count       = cnt_q;
    overflow    = ovf_q;
    underflow   = unf_q;
    Q           = empty ? '0 : mem_q[rp_q];
  end

  // Accept decisions and next-state for pointers, count and sticky flags.
  always_comb begin
    rd_ok = re & ~empty;
    wr_ok = we & (~full | rd_ok);
    rp_d  = rd_ok ? ptr_inc(rp_q) : rp_q;
    wp_d  = wr_ok ? ptr_inc(wp_q) : wp_q;
    cnt_d = cnt_q;
    if (wr_ok & ~rd_ok)      cnt_d = cnt_q + CW'(1);
    else if (rd_ok & ~wr_ok) cnt_d = cnt_q - CW'(1);
    ovf_d = ovf_q | (we & ~wr_ok);
    unf_d = unf_q | (re & ~rd_ok);
  end

  // Control state: reset beats clear beats normal operation; requests in a
  // reset/clear cycle are dropped and raise no flags.
  always_ff @(posedge clock) begin
    if (!reset_l || clear) begin
      rp_q  <= '0;
      wp_q  <= '0;
      cnt_q <= '0;
      ovf_q <= 1'b0;
      unf_q <= 1'b0;
    end else begin
      rp_q  <= rp_d;
      wp_q  <= wp_d;
      cnt_q <= cnt_d;
      ovf_q <= ovf_d;
      unf_q <= unf_d;
    end
  end

  // Storage array: no reset, contents survive clear; writes gated the same way.
  always_ff @(posedge clock) begin
    if (reset_l && !clear && wr_ok) mem_q[wp_q] <= D;
  end

endmodule

// File: tb/tb_sync_fifo.sv
// Directed self-checking bench for sync_fifo: DEPTH=4 instance for the
// main sequence, DEPTH=3 instance for non-power-of-two wrap-around.
module tb_sync_fifo;

  logic       clock = 1'b0;
  logic       reset_l;
  always #5 clock = ~clock;

  // DEPTH=4 instance (AF_LEVEL defaults to 2)
  logic       a_clear, a_we, a_re;
  logic [7:0] a_d, a_q;
  logic       a_empty, a_full, a_af, a_ovf, a_unf;
  logic [2:0] a_cnt;

  // DEPTH=3 instance
  logic       b_clear, b_we, b_re;
  logic [7:0] b_d, b_q;
  logic       b_empty, b_full, b_af, b_ovf, b_unf;
  logic [1:0] b_cnt;

  int errors = 0;
  int checks = 0;

  sync_fifo #(.WIDTH(8), .DEPTH(4)) u_a (
    .clock(clock), .reset_l(reset_l), .clear(a_clear), .we(a_we), .D(a_d),
    .re(a_re), .Q(a_q), .empty(a_empty), .full(a_full), .almost_full(a_af),
    .count(a_cnt), .overflow(a_ovf), .underflow(a_unf));

  sync_fifo #(.WIDTH(8), .DEPTH(3)) u_b (
    .clock(clock), .reset_l(reset_l), .clear(b_clear), .we(b_we), .D(b_d),
    .re(b_re), .Q(b_q), .empty(b_empty), .full(b_full), .almost_full(b_af),
    .count(b_cnt), .overflow(b_ovf), .underflow(b_unf));

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Advance one clock; inputs change and outputs are sampled 1 time unit after the edge.
  task automatic step();
    @(posedge clock);
    #1;
  endtask

  // Check the full status vector of instance A.
  task automatic chk_a(input string tag, input logic [2:0] cnt, input logic [7:0] q,
                       input logic emp, input logic ful, input logic af,
                       input logic ovf, input logic unf);
    check({tag, ".count"}, 32'(a_cnt), 32'(cnt));
    check({tag, ".Q"},     32'(a_q),   32'(q));
    check({tag, ".empty"}, 32'(a_empty), 32'(emp));
    check({tag, ".full"},  32'(a_full),  32'(ful));
    check({tag, ".af"},    32'(a_af),    32'(af));
    check({tag, ".ovf"},   32'(a_ovf),   32'(ovf));
    check({tag, ".unf"},   32'(a_unf),   32'(unf));
  endtask

  initial begin
    reset_l = 1'b0;
    a_clear = 0; a_we = 0; a_re = 0; a_d = '0;
    b_clear = 0; b_we = 0; b_re = 0; b_d = '0;
    #1;

    // 1. reset then idle
    step(); step();
    chk_a("reset", 3'd0, 8'h00, 1, 0, 0, 0, 0);
    check("reset_b.empty", 32'(b_empty), 32'd1);
    check("reset_b.Q", 32'(b_q), 32'd0);
    reset_l = 1'b1;
    step();
    chk_a("idle", 3'd0, 8'h00, 1, 0, 0, 0, 0);

    // 2. fill and overflow
    a_we = 1; a_d = 8'h11; step(); chk_a("w1", 3'd1, 8'h11, 0, 0, 0, 0, 0);
    a_d = 8'h22; step();           chk_a("w2", 3'd2, 8'h11, 0, 0, 1, 0, 0);
    a_d = 8'h33; step();           chk_a("w3", 3'd3, 8'h11, 0, 0, 1, 0, 0);
    a_d = 8'h44; step();           chk_a("w4", 3'd4, 8'h11, 0, 1, 1, 0, 0);
    a_d = 8'h55; step();           chk_a("w5ovf", 3'd4, 8'h11, 0, 1, 1, 1, 0);
    a_we = 0;

    // 3. drain and underflow; Q is sampled in the cycle re is asserted
    a_re = 1;
    check("r1.Q", 32'(a_q), 32'h11); step();
    check("r2.Q", 32'(a_q), 32'h22); step();
    check("r3.Q", 32'(a_q), 32'h33); step();
    check("r4.Q", 32'(a_q), 32'h44); step();
    chk_a("drained", 3'd0, 8'h00, 1, 0, 0, 1, 0);
    step();
    chk_a("r5unf", 3'd0, 8'h00, 1, 0, 0, 1, 1);
    a_re = 0;

    // plain clear drops sticky flags
    a_clear = 1; step(); a_clear = 0;
    chk_a("clr", 3'd0, 8'h00, 1, 0, 0, 0, 0);

    // 4a. simultaneous read/write while full (pointers have wrapped once)
    a_we = 1;
    a_d = 8'h11; step(); a_d = 8'h22; step(); a_d = 8'h33; step(); a_d = 8'h44; step();
    chk_a("refill", 3'd4, 8'h11, 0, 1, 1, 0, 0);
    a_re = 1; a_d = 8'h66;
    check("rwfull.Qpop", 32'(a_q), 32'h11);
    step();
    a_we = 0;
    chk_a("rwfull", 3'd4, 8'h22, 0, 1, 1, 0, 0);
    check("d1.Q", 32'(a_q), 32'h22); step();
    check("d2.Q", 32'(a_q), 32'h33); step();
    check("d3.Q", 32'(a_q), 32'h44); step();
    check("d4.Q", 32'(a_q), 32'h66); step();
    a_re = 0;
    chk_a("rwdrain", 3'd0, 8'h00, 1, 0, 0, 0, 0);

    // 4b. simultaneous read/write while empty: read rejected, write kept
    a_we = 1; a_re = 1; a_d = 8'h77; step();
    a_we = 0; a_re = 0;
    chk_a("rwempty", 3'd1, 8'h77, 0, 0, 0, 0, 1);
    a_re = 1; step(); a_re = 0;
    chk_a("pop77", 3'd0, 8'h00, 1, 0, 0, 0, 1);

    // 6. flush mid-stream with 3 entries and both flags set
    a_we = 1;
    a_d = 8'hA1; step(); a_d = 8'hA2; step(); a_d = 8'hA3; step(); a_d = 8'hA4; step();
    a_d = 8'hA5; step();
    a_we = 0; a_re = 1; step(); a_re = 0;
    chk_a("pre_flush", 3'd3, 8'hA2, 0, 0, 1, 1, 1);
    a_clear = 1; a_we = 1; a_d = 8'hBB; step();
    a_clear = 0; a_we = 0;
    chk_a("flush", 3'd0, 8'h00, 1, 0, 0, 0, 0);
    a_we = 1; a_d = 8'hAA; step(); a_we = 0;
    chk_a("postflush", 3'd1, 8'hAA, 0, 0, 0, 0, 0);

    // 5. wrap on DEPTH=3: seven write/read pairs, pointers cross 2 -> 0
    for (int i = 1; i <= 7; i++) begin
      b_we = 1; b_d = 8'(i); step(); b_we = 0;
      check($sformatf("wrap%0d.count", i), 32'(b_cnt), 32'd1);
      check($sformatf("wrap%0d.Q", i), 32'(b_q), 32'(i));
      b_re = 1; step(); b_re = 0;
      check($sformatf("wrap%0d.empty", i), 32'(b_empty), 32'd1);
    end
    check("wrap.ovf", 32'(b_ovf), 32'd0);
    check("wrap.unf", 32'(b_unf), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
